// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, byte width and round-robin pointer helper.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } uart_arb_state_t;

  function automatic int unsigned next_rr(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational round-robin picker.
// Searches upward from rr_ptr with wrap; first set request wins.
module uart_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int         j;
  logic       found;
  logic [IDX_W-1:0] jj;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = j[IDX_W-1:0];
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one uart_tx.
// One byte in flight; lock held until the last byte completes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_tx_rdy,
  output logic [UART_BYTE_W-1:0]         o_tx_data,
  input  logic                           i_tx_busy,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int BUSY_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);

  uart_arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]         holder_q, holder_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [UART_BYTE_W-1:0]   data_q, data_d;
  logic                     last_q, last_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     err_q, err_d;
  logic [HOLD_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic [BUSY_W-1:0]        busy_cnt_q, busy_cnt_d;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_any;
  logic                     post;

  uart_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (i_req_valid),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    holder_d    = holder_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    last_d      = last_q;
    grant_d     = grant_q;
    err_d       = err_q;
    idle_cnt_d  = idle_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    o_req_ready = '0;
    o_tx_rdy    = 1'b0;
    post        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        o_req_ready = arb_gnt;
        if (arb_any) begin
          data_d   = i_req_data[UART_BYTE_W*int'(arb_idx) +: UART_BYTE_W];
          last_d   = i_req_last[arb_idx];
          holder_d = arb_idx;
          grant_d  = arb_gnt;
          state_d  = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        o_req_ready = grant_q & i_req_valid;
        if (i_req_valid[holder_q]) begin
          data_d     = i_req_data[UART_BYTE_W*int'(holder_q) +: UART_BYTE_W];
          last_d     = i_req_last[holder_q];
          idle_cnt_d = '0;
          state_d    = ST_ISSUE;
        end else if (idle_cnt_q == HOLD_LAST) begin
          // silent holder loses the lock and drops to lowest priority
          rr_ptr_d   = IDX_W'(next_rr(int'(holder_q), NUM_REQ));
          grant_d    = '0;
          idle_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        o_tx_rdy   = 1'b1;
        busy_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (busy_cnt_q == BUSY_LAST) begin
          err_d = 1'b1;
          post  = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) post = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (post) begin
      if (last_q) begin
        rr_ptr_d = IDX_W'(next_rr(int'(holder_q), NUM_REQ));
        grant_d  = '0;
        state_d  = ST_IDLE;
      end else begin
        idle_cnt_d = '0;
        state_d    = ST_HOLD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      holder_q   <= '0;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      idle_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      holder_q   <= holder_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      idle_cnt_q <= idle_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign o_tx_data = data_q;
  assign o_grant   = grant_q;
  assign o_err     = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` serializer between NUM_REQ byte-stream requesters, such as the CPU MMIO port and the debug/trace port.
- Arbitration is round-robin and packet-locked: a requester holds the grant until its byte flagged `last` has been fully transmitted.
- It sequences the serializer's one-cycle `i_rdy` strobe / `o_busy` handshake.
- It sits between the MMIO/debug sources and `uart_tx`, and shares its clock and reset.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- HOLD_TIMEOUT, 1024, idle cycles a locked holder may go without `valid` before its lock is revoked.
- BUSY_TIMEOUT, 8, cycles allowed between `o_tx_rdy` and seeing `i_tx_busy` high before an error is flagged.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester byte valid.
- i_req_data  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_req_last  in  NUM_REQ  byte ends packet; releases the lock after transmit.
- o_req_ready  out  NUM_REQ  byte accepted when valid&ready.
- o_tx_rdy  out  1  one-cycle start strobe to `uart_tx.i_rdy`.
- o_tx_data  out  8  byte to `uart_tx.i_data`; stable from strobe until done.
- i_tx_busy  in  1  `uart_tx.o_busy`.
- o_grant  out  NUM_REQ  one-hot current holder; all zero when unlocked.
- o_err  out  1  sticky; set on busy timeout.

Behaviour:
- Reset (async, i_rst=0) values:
  - o_tx_rdy=0, o_tx_data=0, o_grant=0, o_req_ready=0, o_err=0.
  - rr_ptr=0, counters=0, state=IDLE.
  - Reset mid-byte aborts immediately; no byte is replayed.
- States: IDLE, HOLD, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - sel = first index with valid set, searching from rr_ptr upward with wrap.
  - o_req_ready[sel] is driven combinationally high when any valid is set.
  - On accept: latch data into o_tx_data, latch last, set o_grant=onehot(sel), go to ISSUE.
- HOLD:
  - Only the holder is eligible; o_req_ready[holder]=valid[holder].
  - On accept: go to ISSUE, clear idle_cnt.
  - Otherwise idle_cnt++. When idle_cnt==HOLD_TIMEOUT-1: release the lock, rr_ptr=holder+1 mod NUM_REQ, o_grant=0, go to IDLE.
- ISSUE:
  - o_tx_rdy=1 for exactly this one cycle, then go to WAIT_BUSY with busy_cnt=0.
  - Latency: accept in cycle A, strobe in cycle A+1.
- WAIT_BUSY:
  - If i_tx_busy is high, go to WAIT_DONE.
  - Otherwise busy_cnt++. At BUSY_TIMEOUT-1: set o_err and proceed as if the byte completed (post-byte step).
- WAIT_DONE:
  - Wait for i_tx_busy==0, then run the post-byte step.
- Post-byte step:
  - If latched last=1: rr_ptr=holder+1 mod NUM_REQ, o_grant=0, go to IDLE.
  - Otherwise go to HOLD with idle_cnt=0.
- o_req_ready is 0 in ISSUE, WAIT_BUSY and WAIT_DONE, so exactly one byte is in flight.
- The strobe is never reissued while i_tx_busy=1.
- The next strobe comes at least 2 cycles after busy falls, which guarantees the serializer is back in IDLE.
- Simultaneous valids are resolved by rr_ptr only; the prior holder has lowest priority after a release.
- NUM_REQ=1: rr_ptr stays 0 and the wrap logic degenerates cleanly. The holder index width is max(1,$clog2(NUM_REQ)).
- A `last` on the first byte gives a single-byte packet: the lock is taken and released within that byte.
- o_err clears only on reset.

Decomposition:
- Package uart_pkg:
  - state enum `uart_arb_state_t` (logic [2:0]).
  - localparam `UART_BYTE_W=8`.
  - `function next_rr(idx,n)`.
- Sub-module uart_rr_arb: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: onehot grant, index, any.
  - Parameterised by NUM_REQ.

Test Plan:
Benches use the real `uart_tx` with CLOCK_HZ/BAUD_RATE giving 4 clocks per bit.
1. Single byte: req0 sends 0x55 with last=1 → o_tx_rdy one cycle after accept; o_grant goes 01→00 after busy falls; serial line shows start,1,0,1,0,1,0,1,0,stop; rr_ptr=1.
2. Contention: req0 and req1 both valid from reset, each with a 2-byte packet (0xA1,0xA2 / 0xB1,0xB2) → order A1,A2,B1,B2; req1 ready stays 0 throughout packet A.
3. Fairness: req0 sends 3 back-to-back 1-byte packets while req1 is also valid → order req0,req1,req0,req1…; no requester is starved.
4. Hold timeout: req1 sends a byte with last=0 then drops valid; HOLD_TIMEOUT=16 → grant released exactly 16 cycles after busy falls; a pending req0 is then accepted.
5. Busy timeout: i_tx_busy stub tied 0, BUSY_TIMEOUT=8 → o_err rises 8 cycles after the strobe and stays high; the arbiter continues to the next byte.
6. Reset mid-transfer: assert i_rst=0 during WAIT_DONE → all outputs return to reset values asynchronously; after release, a new req0 byte is transmitted normally.
